// File: rtl/clkdist_seq_ctrl.sv
// Power-up/down and analog test-bus sequencer for the clock distribution block.
// Optional fault entry counter enabled by defining CLKDIST_SEQ_FAULT_CNT_EN.
module clkdist_seq_ctrl #(
   parameter int unsigned BIAS_SETTLE_CYC = 64,
   parameter int unsigned CLK_SETTLE_CYC  = 16,
   parameter int unsigned ATB_SETTLE_CYC  = 8,
   parameter int unsigned CNT_W           = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic       supply_ok,
   input  logic       atb_req,
   input  logic [1:0] atb_sel,
   output logic       atb_ack,
   output logic       pdb,
   output logic [1:0] atb_ena,
   output logic       ready,
   output logic       busy,
   output logic       fault,
   output logic [2:0] state,
   output logic [7:0] fault_cnt
);

   typedef enum logic [2:0] {
      S_OFF       = 3'd0,
      S_BIAS_WAIT = 3'd1,
      S_CLK_WAIT  = 3'd2,
      S_RUN       = 3'd3,
      S_ATB_WAIT  = 3'd4,
      S_SHUTDOWN  = 3'd5,
      S_FAULT     = 3'd6
   } state_t;

   // Bias load carries one extra cycle so pdb rises BIAS_SETTLE_CYC+1 edges after en is sampled.
   localparam logic [CNT_W-1:0] BIAS_LOAD = CNT_W'(BIAS_SETTLE_CYC);
   localparam logic [CNT_W-1:0] CLK_LOAD  = CNT_W'(CLK_SETTLE_CYC - 1);
   localparam logic [CNT_W-1:0] ATB_LOAD  = CNT_W'(ATB_SETTLE_CYC - 1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   state_t           cur, nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             cnt_zero;
   logic             pdb_nxt, ready_nxt, ack_nxt, fault_nxt, busy_nxt;
   logic [1:0]       ena_nxt;

   assign cnt_zero = (cnt == '0);
   assign state    = cur;

   always_ff @(posedge clk) begin
      if (rst) begin
         cur     <= S_OFF;
         cnt     <= '0;
         pdb     <= 1'b0;
         atb_ena <= '0;
         ready   <= 1'b0;
         busy    <= 1'b0;
         atb_ack <= 1'b0;
         fault   <= 1'b0;
      end else begin
         cur     <= nxt;
         cnt     <= cnt_nxt;
         pdb     <= pdb_nxt;
         atb_ena <= ena_nxt;
         ready   <= ready_nxt;
         busy    <= busy_nxt;
         atb_ack <= ack_nxt;
         fault   <= fault_nxt;
      end
   end

   always_comb begin
      nxt = cur;
      if (!supply_ok) begin
         if (cur != S_OFF) nxt = S_FAULT;
      end else begin
         case (cur)
            S_OFF:       if (en) nxt = S_BIAS_WAIT;
            S_BIAS_WAIT: if (!en) nxt = S_SHUTDOWN; else if (cnt_zero) nxt = S_CLK_WAIT;
            S_CLK_WAIT:  if (!en) nxt = S_SHUTDOWN; else if (cnt_zero) nxt = S_RUN;
            S_RUN:       if (!en) nxt = S_SHUTDOWN; else if (atb_req && !atb_ack) nxt = S_ATB_WAIT;
            S_ATB_WAIT:  if (!en) nxt = S_SHUTDOWN; else if (cnt_zero) nxt = S_RUN;
            S_SHUTDOWN:  if (cnt_zero) nxt = S_OFF;
            S_FAULT:     if (!en) nxt = S_OFF;
            default:     nxt = S_OFF;
         endcase
      end
   end

   always_comb begin
      cnt_nxt   = cnt;
      pdb_nxt   = pdb;
      ena_nxt   = atb_ena;
      ready_nxt = ready;
      ack_nxt   = atb_ack;
      fault_nxt = fault;
      busy_nxt  = (nxt == S_BIAS_WAIT) || (nxt == S_CLK_WAIT) ||
                  (nxt == S_ATB_WAIT)  || (nxt == S_SHUTDOWN);
      if (nxt == S_FAULT) begin
         cnt_nxt   = '0;
         pdb_nxt   = 1'b0;
         ena_nxt   = '0;
         ready_nxt = 1'b0;
         ack_nxt   = 1'b0;
         fault_nxt = 1'b1;
      end else if (nxt == S_SHUTDOWN && cur != S_SHUTDOWN) begin
         cnt_nxt   = ATB_LOAD;
         ena_nxt   = '0;
         ready_nxt = 1'b0;
         ack_nxt   = 1'b0;
      end else begin
         case (cur)
            S_OFF: if (nxt == S_BIAS_WAIT) cnt_nxt = BIAS_LOAD;
            S_BIAS_WAIT:
               if (cnt_zero) begin
                  pdb_nxt = 1'b1;
                  cnt_nxt = CLK_LOAD;
               end else cnt_nxt = cnt - CNT_ONE;
            S_CLK_WAIT:
               if (cnt_zero) ready_nxt = 1'b1;
               else cnt_nxt = cnt - CNT_ONE;
            S_RUN: begin
               if (!atb_req) ack_nxt = 1'b0;
               if (nxt == S_ATB_WAIT) begin
                  ena_nxt = atb_sel;
                  cnt_nxt = ATB_LOAD;
               end
            end
            // A request withdrawn while the bus settles is dropped without an ack.
            S_ATB_WAIT:
               if (cnt_zero) ack_nxt = atb_req;
               else cnt_nxt = cnt - CNT_ONE;
            S_SHUTDOWN:
               if (cnt_zero) pdb_nxt = 1'b0;
               else cnt_nxt = cnt - CNT_ONE;
            S_FAULT: if (nxt == S_OFF) fault_nxt = 1'b0;
            default: ;
         endcase
      end
   end

`ifdef CLKDIST_SEQ_FAULT_CNT_EN
   logic [7:0] fcnt;
   always_ff @(posedge clk) begin
      if (rst) fcnt <= '0;
      else if (nxt == S_FAULT && cur != S_FAULT && fcnt != 8'hFF) fcnt <= fcnt + 8'd1;
   end
   assign fault_cnt = fcnt;
`else
   assign fault_cnt = '0;
`endif

endmodule

// File: tb/tb_clkdist_seq_ctrl.sv
// Scoreboard bench for clkdist_seq_ctrl: directed stimulus queues cycle-stamped
// expected outputs, a negedge monitor pops and compares them.
module tb_clkdist_seq_ctrl;

   logic       clk = 1'b0;
   logic       rst, en, supply_ok, atb_req;
   logic [1:0] atb_sel;
   logic       atb_ack, pdb, ready, busy, fault;
   logic [1:0] atb_ena;
   logic [2:0] state;
   logic [7:0] fault_cnt;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   logic [7:0] fc_exp = '0;

   typedef struct {
      int          cyc;
      logic [17:0] vec;
      string       name;
   } exp_t;
   exp_t q[$];
   exp_t mon_e;

   clkdist_seq_ctrl #(
      .BIAS_SETTLE_CYC(64),
      .CLK_SETTLE_CYC (16),
      .ATB_SETTLE_CYC (8),
      .CNT_W          (8)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .supply_ok(supply_ok),
      .atb_req  (atb_req),
      .atb_sel  (atb_sel),
      .atb_ack  (atb_ack),
      .pdb      (pdb),
      .atb_ena  (atb_ena),
      .ready    (ready),
      .busy     (busy),
      .fault    (fault),
      .state    (state),
      .fault_cnt(fault_cnt)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      while (q.size() > 0 && q[0].cyc <= cyc) begin
         mon_e = q.pop_front();
         total++;
         if (mon_e.cyc != cyc) begin
            bad++;
            $display("FAIL %s: missed check at cycle %0d (now %0d)", mon_e.name, mon_e.cyc, cyc);
         end else if ({state, pdb, atb_ena, ready, busy, atb_ack, fault, fault_cnt} !== mon_e.vec) begin
            bad++;
            $display("FAIL %s cyc=%0d: got st=%0d pdb=%b ena=%b rdy=%b busy=%b ack=%b flt=%b fcnt=%0d; required {st,pdb,ena,rdy,busy,ack,flt,fcnt}=%b",
                     mon_e.name, cyc, state, pdb, atb_ena, ready, busy, atb_ack, fault, fault_cnt, mon_e.vec);
         end
      end
   end

   task automatic push(input int d, input string name, input logic [2:0] st, input logic p,
                       input logic [1:0] ena, input logic rdy, input logic bsy,
                       input logic ack, input logic flt);
      exp_t e;
      e.cyc  = cyc + d;
      e.vec  = {st, p, ena, rdy, bsy, ack, flt, fc_exp};
      e.name = name;
      q.push_back(e);
   endtask

   task automatic drain(input int budget);
      int n = 0;
      while (q.size() > 0 && n < budget) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (q.size() > 0) begin
         total++;
         bad++;
         $display("FAIL drain_timeout: %0d checks pending after %0d cycles, required 0", q.size(), budget);
         q.delete();
      end
   endtask

   task automatic note_fault();
`ifdef CLKDIST_SEQ_FAULT_CNT_EN
      fc_exp = fc_exp + 8'd1;
`endif
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; en = 1'b0; supply_ok = 1'b1; atb_req = 1'b0; atb_sel = 2'b00;
      repeat (2) @(negedge clk);
      push(1, "reset", 3'd0, 0, 2'b00, 0, 0, 0, 0);
      drain(5);
      rst = 1'b0;

      // supply out of bounds while OFF: no fault, no power-up
      en = 1'b1; supply_ok = 1'b0;
      push(1, "off_nosupply_1", 3'd0, 0, 2'b00, 0, 0, 0, 0);
      push(2, "off_nosupply_2", 3'd0, 0, 2'b00, 0, 0, 0, 0);
      drain(5);
      en = 1'b0; supply_ok = 1'b1;
      push(1, "off_idle", 3'd0, 0, 2'b00, 0, 0, 0, 0);
      drain(5);

      // power-up
      en = 1'b1;
      push(1,  "bias_enter", 3'd1, 0, 2'b00, 0, 1, 0, 0);
      push(65, "bias_last",  3'd1, 0, 2'b00, 0, 1, 0, 0);
      push(66, "pdb_rise",   3'd2, 1, 2'b00, 0, 1, 0, 0);
      push(81, "clk_last",   3'd2, 1, 2'b00, 0, 1, 0, 0);
      push(82, "ready_rise", 3'd3, 1, 2'b00, 1, 0, 0, 0);
      drain(200);

      // ATB handshake, code 11
      atb_sel = 2'b11; atb_req = 1'b1;
      push(1,  "atb_ena_set",  3'd4, 1, 2'b11, 1, 1, 0, 0);
      push(8,  "atb_settling", 3'd4, 1, 2'b11, 1, 1, 0, 0);
      push(9,  "atb_ack_rise", 3'd3, 1, 2'b11, 1, 0, 1, 0);
      push(10, "atb_ack_hold", 3'd3, 1, 2'b11, 1, 0, 1, 0);
      drain(30);
      atb_req = 1'b0;
      push(1, "atb_ack_clear", 3'd3, 1, 2'b11, 1, 0, 0, 0);
      push(2, "atb_ena_hold",  3'd3, 1, 2'b11, 1, 0, 0, 0);
      drain(10);

      // select 01, then shutdown
      atb_sel = 2'b01; atb_req = 1'b1;
      push(1, "atb01_set", 3'd4, 1, 2'b01, 1, 1, 0, 0);
      push(9, "atb01_ack", 3'd3, 1, 2'b01, 1, 0, 1, 0);
      drain(30);
      atb_req = 1'b0;
      push(1, "atb01_ack_clear", 3'd3, 1, 2'b01, 1, 0, 0, 0);
      drain(10);
      en = 1'b0;
      push(1, "sd_enter", 3'd5, 1, 2'b00, 0, 1, 0, 0);
      push(8, "sd_last",  3'd5, 1, 2'b00, 0, 1, 0, 0);
      push(9, "sd_off",   3'd0, 0, 2'b00, 0, 0, 0, 0);
      drain(30);

      // supply fault during CLK_WAIT
      en = 1'b1;
      push(66, "clkwait_a", 3'd2, 1, 2'b00, 0, 1, 0, 0);
      push(70, "clkwait_b", 3'd2, 1, 2'b00, 0, 1, 0, 0);
      drain(100);
      supply_ok = 1'b0;
      note_fault();
      push(1, "fault_enter", 3'd6, 0, 2'b00, 0, 0, 0, 1);
      drain(5);
      supply_ok = 1'b1;
      push(1, "fault_hold_en1_a", 3'd6, 0, 2'b00, 0, 0, 0, 1);
      push(2, "fault_hold_en1_b", 3'd6, 0, 2'b00, 0, 0, 0, 1);
      drain(5);
      en = 1'b0;
      push(1, "fault_exit", 3'd0, 0, 2'b00, 0, 0, 0, 0);
      drain(5);

      // abort during bias settling
      en = 1'b1;
      push(1,  "abort_bias_enter", 3'd1, 0, 2'b00, 0, 1, 0, 0);
      push(10, "abort_bias_c10",   3'd1, 0, 2'b00, 0, 1, 0, 0);
      drain(20);
      en = 1'b0;
      push(1, "abort_sd_enter", 3'd5, 0, 2'b00, 0, 1, 0, 0);
      push(8, "abort_sd_last",  3'd5, 0, 2'b00, 0, 1, 0, 0);
      push(9, "abort_off",      3'd0, 0, 2'b00, 0, 0, 0, 0);
      drain(20);

      // request raised during BIAS_WAIT stays pending until RUN
      en = 1'b1;
      push(1, "early_bias", 3'd1, 0, 2'b00, 0, 1, 0, 0);
      drain(5);
      atb_sel = 2'b10; atb_req = 1'b1;
      push(65, "early_pdb",     3'd2, 1, 2'b00, 0, 1, 0, 0);
      push(81, "early_run",     3'd3, 1, 2'b00, 1, 0, 0, 0);
      push(82, "early_service", 3'd4, 1, 2'b10, 1, 1, 0, 0);
      push(90, "early_ack",     3'd3, 1, 2'b10, 1, 0, 1, 0);
      drain(120);

      // request withdrawn while settling: no ack
      atb_req = 1'b0;
      push(1, "early_ack_clear", 3'd3, 1, 2'b10, 1, 0, 0, 0);
      drain(5);
      atb_sel = 2'b01; atb_req = 1'b1;
      push(1, "drop_set", 3'd4, 1, 2'b01, 1, 1, 0, 0);
      drain(5);
      atb_req = 1'b0;
      push(7, "drop_settling", 3'd4, 1, 2'b01, 1, 1, 0, 0);
      push(8, "drop_no_ack",   3'd3, 1, 2'b01, 1, 0, 0, 0);
      drain(20);

      // supply fault from RUN, recover, then reset clears the fault counter
      supply_ok = 1'b0;
      note_fault();
      push(1, "run_fault", 3'd6, 0, 2'b00, 0, 0, 0, 1);
      drain(5);
      supply_ok = 1'b1; en = 1'b0;
      push(1, "run_fault_exit", 3'd0, 0, 2'b00, 0, 0, 0, 0);
      drain(5);
      rst = 1'b1;
      fc_exp = '0;
      push(1, "final_reset", 3'd0, 0, 2'b00, 0, 0, 0, 0);
      drain(5);
      rst = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
